// File: rtl/cache_bus_responder_if.sv
// Cache <-> memory-side responder bus: line request, beat steering and completion.
interface cache_bus_responder_if #(
    parameter int PA_BITS = 32,
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64,
    parameter int LOGBWPL = $clog2(LINELEN / BEATLEN)
);
    logic [1:0]         CacheBusRW;
    logic [PA_BITS-1:0] CacheBusAdr;
    logic [BEATLEN-1:0] ReadDataWord;
    logic [LOGBWPL-1:0] BeatCount;
    logic               SelBusBeat;
    logic [LINELEN-1:0] FetchBuffer;
    logic               CacheBusAck;
    logic               BusErr;

    // Cache side: issues requests and supplies writeback beats.
    modport master (
        output CacheBusRW,
        output CacheBusAdr,
        output ReadDataWord,
        input  BeatCount,
        input  SelBusBeat,
        input  FetchBuffer,
        input  CacheBusAck,
        input  BusErr
    );

    // Memory side: serves requests from its backing store.
    modport slave (
        input  CacheBusRW,
        input  CacheBusAdr,
        input  ReadDataWord,
        output BeatCount,
        output SelBusBeat,
        output FetchBuffer,
        output CacheBusAck,
        output BusErr
    );
endinterface

// File: rtl/cache_bus_responder.sv
// Memory-side responder for cache line fetch / writeback bursts.
// Requests are accepted only in IDLE, optionally delayed by LATENCY wait
// cycles, then served one beat per cycle against a line-organised store.
module cache_bus_responder #(
    parameter int PA_BITS  = 32,
    parameter int LINELEN  = 512,
    parameter int BEATLEN  = 64,
    parameter int LOGBWPL  = $clog2(LINELEN / BEATLEN),
    parameter int MEMLINES = 256,
    parameter int LATENCY  = 2
) (
    input logic                  clk,
    input logic                  resetn,
    cache_bus_responder_if.slave bus
);
    localparam int NBEATS    = LINELEN / BEATLEN;
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
    localparam int LIW       = PA_BITS - OFFSETLEN;
    localparam int MLW       = $clog2(MEMLINES);
    localparam int ROWS      = MEMLINES * NBEATS;
    localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        RDBURST = 3'd2,
        WRBURST = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [LOGBWPL-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [MLW-1:0]     idx_q, idx_d;
    logic               wr_q, wr_d;
    logic               oor_q, oor_d;
    logic [LINELEN-1:0] fb_q, fb_d;

    // One row per beat; row address is {line index, beat index}.
    logic [BEATLEN-1:0] mem [ROWS];

    logic [LIW-1:0]         req_li;
    logic                   req_oor;
    logic                   last_beat;
    logic                   lat_done;
    logic                   mem_we;
    logic [MLW+LOGBWPL-1:0] row;
    logic [BEATLEN-1:0]     rd_word;
    logic                   unused_adr_bits;

    // Request decode and per-beat addressing.
    always_comb begin
        req_li    = bus.CacheBusAdr[PA_BITS-1:OFFSETLEN];
        req_oor   = ({1'b0, req_li} >= (LIW+1)'(MEMLINES));
        last_beat = (beat_q == LOGBWPL'(NBEATS - 1));
        lat_done  = (lat_q == LAT_W'(LATENCY - 1));
        row       = {idx_q, beat_q};
        rd_word   = mem[row];
        mem_we    = (state_q == WRBURST) && !oor_q;
    end

    // Offset bits are ignored: requests are line-aligned.
    assign unused_adr_bits = ^bus.CacheBusAdr[OFFSETLEN-1:0];

    // Backing store write port; not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[row] <= bus.ReadDataWord;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: write wins when both directions are requested.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.CacheBusRW != 2'b00) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = bus.CacheBusRW[0] ? WRBURST : RDBURST;
                    end
                end
            end
            WAIT: begin
                if (lat_done) begin
                    state_d = wr_q ? WRBURST : RDBURST;
                end
            end
            RDBURST, WRBURST: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on acceptance, count waits and beats,
    // and fill the fetch buffer one slice per read beat.
    always_comb begin
        beat_d = beat_q;
        lat_d  = lat_q;
        idx_d  = idx_q;
        wr_d   = wr_q;
        oor_d  = oor_q;
        fb_d   = fb_q;
        unique case (state_q)
            IDLE: begin
                if (bus.CacheBusRW != 2'b00) begin
                    idx_d  = req_li[MLW-1:0];
                    oor_d  = req_oor;
                    wr_d   = bus.CacheBusRW[0];
                    lat_d  = '0;
                    beat_d = '0;
                end
            end
            WAIT: begin
                lat_d = lat_q + LAT_W'(1);
            end
            RDBURST: begin
                fb_d[beat_q*BEATLEN +: BEATLEN] = oor_q ? '0 : rd_word;
                beat_d = last_beat ? '0 : beat_q + LOGBWPL'(1);
            end
            WRBURST: begin
                beat_d = last_beat ? '0 : beat_q + LOGBWPL'(1);
            end
            default: begin
                beat_d = '0;
            end
        endcase
    end

    // Datapath registers; everything observable returns to zero on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_q <= '0;
            lat_q  <= '0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
            oor_q  <= 1'b0;
            fb_q   <= '0;
        end else begin
            beat_q <= beat_d;
            lat_q  <= lat_d;
            idx_q  <= idx_d;
            wr_q   <= wr_d;
            oor_q  <= oor_d;
            fb_q   <= fb_d;
        end
    end

    // FSM outputs: steering during writebacks, single-cycle completion.
    always_comb begin
        bus.BeatCount   = beat_q;
        bus.SelBusBeat  = (state_q == WRBURST);
        bus.CacheBusAck = (state_q == DONE);
        bus.BusErr      = (state_q == DONE) && oor_q;
        bus.FetchBuffer = fb_q;
    end
endmodule

// File: tb/tb_cache_bus_responder.sv
// Randomised self-checking bench for cache_bus_responder against a line-level model.
module tb_cache_bus_responder;
    localparam int PA_BITS   = 32;
    localparam int LINELEN   = 512;
    localparam int BEATLEN   = 64;
    localparam int NB        = LINELEN / BEATLEN;
    localparam int LOGBWPL   = $clog2(NB);
    localparam int MEMLINES  = 256;
    localparam int LAT       = 2;
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
    localparam int TXN_CYC   = LAT + NB + 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cache_bus_responder_if #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN)) bi ();
    cache_bus_responder_if #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN)) bi0 ();

    cache_bus_responder #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN),
                          .MEMLINES(MEMLINES), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .bus(bi));

    cache_bus_responder #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN),
                          .MEMLINES(MEMLINES), .LATENCY(0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(bi0));

    int checks = 0;
    int errors = 0;

    logic [BEATLEN-1:0] ref_mem [MEMLINES*NB];
    logic [BEATLEN-1:0] wline [NB];

    int               ack_at;
    logic             ack_post, err_post;
    logic [LOGBWPL-1:0] bc_tr [64];
    logic             sel_tr [64];
    logic             err_tr [64];

    function automatic logic [LINELEN-1:0] model_line(input int li);
        logic [LINELEN-1:0] l;
        l = '0;
        if (li < MEMLINES)
            for (int k = 0; k < NB; k++) l[k*BEATLEN +: BEATLEN] = ref_mem[li*NB + k];
        return l;
    endfunction

    function automatic void model_write(input int li);
        if (li < MEMLINES)
            for (int k = 0; k < NB; k++) ref_mem[li*NB + k] = wline[k];
    endfunction

    function automatic logic [LINELEN-1:0] packed_wline();
        logic [LINELEN-1:0] l;
        for (int k = 0; k < NB; k++) l[k*BEATLEN +: BEATLEN] = wline[k];
        return l;
    endfunction

    // Acts as the cache: present a request from an IDLE cycle, feed writeback
    // beats via BeatCount, move the address at cycle 2, and record a trace.
    task automatic run_txn(input logic [1:0] rw, input int li, input int li_mid,
                           input logic [1:0] rw_after);
        for (int n = 0; n < 64; n++) begin
            bc_tr[n] = 'x; sel_tr[n] = 1'bx; err_tr[n] = 1'bx;
        end
        ack_at = -1;
        bi.CacheBusRW  = rw;
        bi.CacheBusAdr = PA_BITS'(li) << OFFSETLEN;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bc_tr[n]  = bi.BeatCount;
            sel_tr[n] = bi.SelBusBeat;
            err_tr[n] = bi.BusErr;
            if (n == 2) bi.CacheBusAdr = PA_BITS'(li_mid) << OFFSETLEN;
            bi.ReadDataWord = wline[bi.BeatCount];
            if (bi.CacheBusAck === 1'b1) begin
                ack_at = n;
                bi.CacheBusRW = rw_after;
                break;
            end
        end
        if (ack_at < 0) bi.CacheBusRW = 2'b00;
        @(posedge clk); #1;
        ack_post = bi.CacheBusAck;
        err_post = bi.BusErr;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bi.CacheBusRW = 2'b00; bi.CacheBusAdr = '0; bi.ReadDataWord = '0;
        bi0.CacheBusRW = 2'b00; bi0.CacheBusAdr = '0; bi0.ReadDataWord = '0;
        #3;
        checks++;
        if ({bi.BeatCount, bi.SelBusBeat, bi.CacheBusAck, bi.BusErr} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got beat=%0d sel=%b ack=%b err=%b, want all 0",
                     bi.BeatCount, bi.SelBusBeat, bi.CacheBusAck, bi.BusErr);
        end
        checks++;
        if (bi.FetchBuffer !== '0) begin
            errors++;
            $display("FAIL reset_fetchbuf: got %h want 0", bi.FetchBuffer);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bi0.BeatCount, bi0.SelBusBeat, bi0.CacheBusAck, bi0.BusErr, bi.CacheBusAck} !== '0) begin
            errors++;
            $display("FAIL reset_idle: outputs not quiet after reset release");
        end
    endtask

    task automatic test_preload();
        for (int li = 0; li < 16; li++) begin
            for (int k = 0; k < NB; k++)
                wline[k] = (li == 5) ? (64'h1111_0000_0000_0000 | 64'(k)) : {$urandom, $urandom};
            run_txn(2'b01, li, li, 2'b00);
            model_write(li);
            checks++;
            if (ack_at !== TXN_CYC) begin
                errors++;
                $display("FAIL preload_ack line %0d: got cycle %0d want %0d", li, ack_at, TXN_CYC);
            end
        end
    endtask

    task automatic test_fetch();
        int bad, first, exp_bc;
        run_txn(2'b10, 5, 5, 2'b00);
        checks++;
        if (ack_at !== TXN_CYC) begin
            errors++;
            $display("FAIL fetch_ack_cycle: got %0d want %0d", ack_at, TXN_CYC);
        end
        checks++;
        if (bi.FetchBuffer[127:64] !== 64'h1111_0000_0000_0001) begin
            errors++;
            $display("FAIL fetch_beat1: got %h want 1111000000000001", bi.FetchBuffer[127:64]);
        end
        checks++;
        if (bi.FetchBuffer !== model_line(5)) begin
            errors++;
            $display("FAIL fetch_line5: got %h want %h", bi.FetchBuffer, model_line(5));
        end
        checks++;
        if ({(ack_at > 0) ? err_tr[ack_at] : 1'bx, ack_post} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_err_or_long_ack: got err/ack_after=%b%b want 00",
                     (ack_at > 0) ? err_tr[ack_at] : 1'bx, ack_post);
        end
        bad = 0; first = -1;
        for (int n = 1; n <= TXN_CYC; n++) begin
            exp_bc = (n >= LAT + 1 && n <= LAT + NB) ? n - LAT - 1 : 0;
            if (bc_tr[n] !== LOGBWPL'(exp_bc) || sel_tr[n] !== 1'b0) begin
                bad++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fetch_beat_trace: %0d cycles differ, first at %0d (beat %0d sel %b)",
                     bad, first, bc_tr[first], sel_tr[first]);
        end
    endtask

    task automatic test_writeback();
        int bad, sel_n, exp_bc;
        logic [LINELEN-1:0] fb_before;
        fb_before = bi.FetchBuffer;
        for (int k = 0; k < NB; k++) wline[k] = 64'hA0 + 64'(k);
        run_txn(2'b01, 7, 7, 2'b00);
        model_write(7);
        checks++;
        if (ack_at !== TXN_CYC) begin
            errors++;
            $display("FAIL wb_ack_cycle: got %0d want %0d", ack_at, TXN_CYC);
        end
        bad = 0; sel_n = 0;
        for (int n = 1; n <= TXN_CYC; n++) begin
            exp_bc = (n >= LAT + 1 && n <= LAT + NB) ? n - LAT - 1 : 0;
            if (sel_tr[n] === 1'b1) sel_n++;
            if (bc_tr[n] !== LOGBWPL'(exp_bc) || sel_tr[n] !== (exp_bc != 0 || n == LAT + 1))
                bad++;
        end
        checks++;
        if (bad != 0 || sel_n != NB) begin
            errors++;
            $display("FAIL wb_sel_trace: got %0d sel cycles (%0d bad) want %0d", sel_n, bad, NB);
        end
        checks++;
        if (bi.FetchBuffer !== fb_before) begin
            errors++;
            $display("FAIL wb_fetchbuf_hold: got %h want %h", bi.FetchBuffer, fb_before);
        end
        run_txn(2'b10, 7, 7, 2'b00);
        checks++;
        if (bi.FetchBuffer[3*BEATLEN +: BEATLEN] !== 64'hA3) begin
            errors++;
            $display("FAIL wb_readback_beat3: got %h want a3", bi.FetchBuffer[3*BEATLEN +: BEATLEN]);
        end
        checks++;
        if (bi.FetchBuffer !== model_line(7)) begin
            errors++;
            $display("FAIL wb_readback_line: got %h want %h", bi.FetchBuffer, model_line(7));
        end
    endtask

    task automatic test_back_to_back();
        int sel_n;
        for (int k = 0; k < NB; k++) wline[k] = {$urandom, $urandom};
        run_txn(2'b11, 9, 9, 2'b10);
        model_write(9);
        sel_n = 0;
        for (int n = 1; n <= TXN_CYC; n++) if (sel_tr[n] === 1'b1) sel_n++;
        checks++;
        if (ack_at !== TXN_CYC || sel_n != NB) begin
            errors++;
            $display("FAIL b2b_write_first: got ack %0d sel %0d want ack %0d sel %0d",
                     ack_at, sel_n, TXN_CYC, NB);
        end
        run_txn(2'b10, 9, 9, 2'b00);
        checks++;
        if (ack_at !== TXN_CYC) begin
            errors++;
            $display("FAIL b2b_read_ack: got %0d want %0d", ack_at, TXN_CYC);
        end
        checks++;
        if (bi.FetchBuffer !== model_line(9)) begin
            errors++;
            $display("FAIL b2b_read_data: got %h want %h", bi.FetchBuffer, model_line(9));
        end
    endtask

    task automatic test_out_of_range();
        int early_err;
        run_txn(2'b10, MEMLINES, MEMLINES, 2'b00);
        checks++;
        if (bi.FetchBuffer !== '0) begin
            errors++;
            $display("FAIL oor_fetchbuf: got %h want 0", bi.FetchBuffer);
        end
        early_err = 0;
        for (int n = 1; n < TXN_CYC; n++) if (err_tr[n] !== 1'b0) early_err++;
        checks++;
        if (ack_at !== TXN_CYC || ((ack_at > 0) ? err_tr[ack_at] : 1'bx) !== 1'b1 || early_err != 0) begin
            errors++;
            $display("FAIL oor_ack_err: got ack %0d err %b early %0d want ack %0d err 1",
                     ack_at, (ack_at > 0) ? err_tr[ack_at] : 1'bx, early_err, TXN_CYC);
        end
        checks++;
        if ({ack_post, err_post} !== 2'b00) begin
            errors++;
            $display("FAIL oor_pulse_width: got ack/err after %b%b want 00", ack_post, err_post);
        end
        for (int k = 0; k < NB; k++) wline[k] = {$urandom, $urandom};
        run_txn(2'b01, MEMLINES + 5, MEMLINES + 5, 2'b00);
        run_txn(2'b10, 5, 5, 2'b00);
        checks++;
        if (bi.FetchBuffer !== model_line(5)) begin
            errors++;
            $display("FAIL oor_write_discard: got %h want %h", bi.FetchBuffer, model_line(5));
        end
    endtask

    task automatic test_reset_midburst();
        bit found;
        int acks;
        for (int k = 0; k < NB; k++) wline[k] = {$urandom, $urandom};
        bi.CacheBusRW  = 2'b01;
        bi.CacheBusAdr = PA_BITS'(2) << OFFSETLEN;
        found = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bi.ReadDataWord = wline[bi.BeatCount];
            if (bi.SelBusBeat === 1'b1 && bi.BeatCount == 3) begin
                found = 1;
                break;
            end
        end
        resetn = 1'b0;
        bi.CacheBusRW = 2'b00;
        #1;
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reach_beat3: got found=%b want 1", found);
        end
        checks++;
        if ({bi.BeatCount, bi.SelBusBeat, bi.CacheBusAck, bi.BusErr} !== '0 || bi.FetchBuffer !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got beat=%0d sel=%b ack=%b err=%b, want all 0",
                     bi.BeatCount, bi.SelBusBeat, bi.CacheBusAck, bi.BusErr);
        end
        for (int k = 0; k < 3; k++) ref_mem[2*NB + k] = wline[k];
        @(posedge clk); #1;
        resetn = 1'b1;
        acks = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (bi.CacheBusAck !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL rst_mid_no_ack: got %0d ack cycles want 0", acks);
        end
        run_txn(2'b10, 2, 2, 2'b00);
        checks++;
        if (bi.FetchBuffer !== model_line(2)) begin
            errors++;
            $display("FAIL rst_mid_partial: got %h want %h", bi.FetchBuffer, model_line(2));
        end
    endtask

    task automatic test_latency0();
        logic [BEATLEN-1:0] lw [NB];
        logic [LINELEN-1:0] lw_line;
        int ack;
        logic sel1;
        logic [LOGBWPL-1:0] bc2;
        for (int k = 0; k < NB; k++) begin
            lw[k] = {$urandom, $urandom};
            lw_line[k*BEATLEN +: BEATLEN] = lw[k];
        end
        bi0.CacheBusRW = 2'b01;
        bi0.CacheBusAdr = PA_BITS'(3) << OFFSETLEN;
        ack = -1; sel1 = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) sel1 = bi0.SelBusBeat;
            bi0.ReadDataWord = lw[bi0.BeatCount];
            if (bi0.CacheBusAck === 1'b1) begin ack = n; break; end
        end
        bi0.CacheBusRW = 2'b00;
        checks++;
        if (ack !== NB + 1 || sel1 !== 1'b1) begin
            errors++;
            $display("FAIL lat0_write: got ack %0d sel@1 %b want ack %0d sel@1 1", ack, sel1, NB + 1);
        end
        @(posedge clk); #1;
        bi0.CacheBusRW = 2'b10;
        bi0.CacheBusAdr = PA_BITS'(3) << OFFSETLEN;
        ack = -1; bc2 = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin
                bc2 = bi0.BeatCount;
                bi0.CacheBusAdr = PA_BITS'(4) << OFFSETLEN;
            end
            if (bi0.CacheBusAck === 1'b1) begin ack = n; break; end
        end
        bi0.CacheBusRW = 2'b00;
        checks++;
        if (ack !== NB + 1 || bc2 !== LOGBWPL'(1)) begin
            errors++;
            $display("FAIL lat0_read_timing: got ack %0d beat@2 %0d want ack %0d beat@2 1", ack, bc2, NB + 1);
        end
        checks++;
        if (bi0.FetchBuffer !== lw_line) begin
            errors++;
            $display("FAIL lat0_read_data: got %h want %h", bi0.FetchBuffer, lw_line);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int li, mid;
        bit is_wr, is_oor;
        for (int it = 0; it < 40; it++) begin
            is_wr  = ($urandom_range(0, 1) == 1);
            is_oor = ($urandom_range(0, 5) == 0);
            li     = is_oor ? int'($urandom_range(MEMLINES, 4000)) : int'($urandom_range(0, 15));
            mid    = int'($urandom_range(0, 15));
            for (int k = 0; k < NB; k++) wline[k] = {$urandom, $urandom};
            run_txn(is_wr ? 2'b01 : 2'b10, li, mid, 2'b00);
            checks++;
            if (ack_at !== TXN_CYC || ((ack_at > 0) ? err_tr[ack_at] : 1'bx) !== is_oor) begin
                errors++;
                $display("FAIL rand%0d_ack: got ack %0d err %b want ack %0d err %b", it, ack_at,
                         (ack_at > 0) ? err_tr[ack_at] : 1'bx, TXN_CYC, is_oor);
            end
            if (is_wr) begin
                model_write(li);
            end else begin
                checks++;
                if (bi.FetchBuffer !== model_line(li)) begin
                    errors++;
                    $display("FAIL rand%0d_read line %0d: got %h want %h", it, li,
                             bi.FetchBuffer, model_line(li));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_preload();
        test_fetch();
        test_writeback();
        test_back_to_back();
        test_out_of_range();
        test_reset_midburst();
        test_latency0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
